// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO whose drain FSM feeds a UART transmitter din/din_vld/rfd handshake
// Sticky overflow flag is built only when UART_TX_FIFO_OVF_EN is defined; otherwise ovf is tied low.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [DATA_WIDTH-1:0] uart_din,
  output logic                  uart_din_vld,
  input  logic                  uart_rfd,
  output logic                  ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY} state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_vld;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = (r_state == S_ISSUE);
  // A pop in the same cycle frees a slot, so a write into a full FIFO is still taken.
  assign w_push  = wr_en && !rst && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // WAIT_BUSY blocks a second issue until the transmitter has visibly taken the word (rfd low).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_din   <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (uart_rfd && !w_empty) begin
            r_din   <= r_mem[r_rd_ptr];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_vld   <= 1'b1;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!uart_rfd) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (wr_en && !w_push) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign full         = w_full;
  assign almost_full  = (r_count >= AF_CNT);
  assign empty        = w_empty;
  assign count        = r_count;
  assign uart_din     = r_din;
  assign uart_din_vld = r_vld;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo (queue model plus directed scenarios)
// Expected ovf behaviour follows UART_TX_FIFO_OVF_EN when it is defined for the build.
module tb_uart_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
`ifdef UART_TX_FIFO_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          full;
  logic          almost_full;
  logic          empty;
  logic [4:0]    count;
  logic [DW-1:0] uart_din;
  logic          uart_din_vld;
  logic          uart_rfd;
  logic          ovf;

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .full         (full),
    .almost_full  (almost_full),
    .empty        (empty),
    .count        (count),
    .uart_din     (uart_din),
    .uart_din_vld (uart_din_vld),
    .uart_rfd     (uart_rfd),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a queue of stored words plus the issue/hold status of the drain side.
  logic [DW-1:0] q[$];
  logic [DW-1:0] out_log[$];
  bit            m_arm  = 1'b0;
  bit            m_hold = 1'b0;
  bit            m_vld  = 1'b0;
  bit            m_ovf  = 1'b0;
  bit            seen_rst = 1'b0;
  logic [DW-1:0] m_din = '0;
  int            m_sz;
  bit            m_pop;

  initial forever begin
    @(negedge clk);
    if (seen_rst) begin
      chk("count",       32'(count),        32'(q.size()));
      chk("empty",       32'(empty),        32'(q.size() == 0));
      chk("full",        32'(full),         32'(q.size() == DEPTH));
      chk("almost_full", 32'(almost_full),  32'(q.size() >= AF));
      chk("ovf",         32'(ovf),          32'(m_ovf));
      chk("din_vld",     32'(uart_din_vld), 32'(m_vld));
      chk("din",         32'(uart_din),     32'(m_din));
      if (uart_din_vld === 1'b1) out_log.push_back(uart_din);
    end
    if (rst) begin
      q.delete();
      m_arm = 1'b0; m_hold = 1'b0; m_vld = 1'b0; m_ovf = 1'b0; m_din = '0;
      seen_rst = 1'b1;
    end else if (seen_rst) begin
      m_sz  = q.size();
      m_pop = m_arm;
      if (m_pop) begin
        void'(q.pop_front());
        m_arm  = 1'b0;
        m_hold = 1'b1;
      end else if (m_hold) begin
        if (!uart_rfd) m_hold = 1'b0;
      end else if (uart_rfd && m_sz != 0) begin
        m_arm = 1'b1;
        m_din = q[0];
      end
      if (wr_en) begin
        if (m_sz < DEPTH || m_pop) q.push_back(wr_data);
        else if (OVF_EN) m_ovf = 1'b1;
      end
      m_vld = m_pop;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] d);
    tick;
    wr_en = 1'b1;
    wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic wait_vld(input int limit);
    int n = 0;
    while (uart_din_vld !== 1'b1 && n < limit) begin
      tick;
      n++;
    end
  endtask

  // Transmitter that goes busy for 'gap' cycles after each accepted word.
  task automatic xmit(input int n, input int gap);
    int got = 0;
    int guard = 0;
    uart_rfd = 1'b1;
    while (got < n && guard < 20000) begin
      tick;
      guard++;
      if (uart_din_vld === 1'b1) begin
        got++;
        uart_rfd = 1'b0;
        repeat (gap) tick;
        uart_rfd = 1'b1;
      end
    end
    chk("xmit_pulses", 32'(got), 32'(n));
  endtask

  task automatic wr_stream;
    int i = 0;
    int g = 0;
    while (i < 40 && g < 6000) begin
      tick;
      g++;
      if (!full && $urandom_range(0, 2) != 0) begin
        wr_en = 1'b1;
        wr_data = 8'(i);
        i++;
      end else begin
        wr_en = 1'b0;
      end
    end
    tick;
    wr_en = 1'b0;
  endtask

  task automatic tx_random;
    int guard = 0;
    uart_rfd = 1'b1;
    while (out_log.size() < 40 && guard < 6000) begin
      tick;
      guard++;
      if (uart_din_vld === 1'b1) begin
        uart_rfd = 1'b0;
        repeat ($urandom_range(1, 5)) tick;
        uart_rfd = 1'b1;
      end else if ($urandom_range(0, 7) == 0) begin
        uart_rfd = 1'b0;
        repeat ($urandom_range(1, 4)) tick;
        uart_rfd = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < out_log.size()) return 32'(out_log[i]);
    return 32'hDEAD_BEEF;
  endfunction

  int t0;

  initial begin
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; uart_rfd = 1'b1;
    tick;
    tick;
    rst = 1'b0; wr_en = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_din", 32'(uart_din), 0);
    chk("rst_vld", 32'(uart_din_vld), 0);
    chk("rst_ovf", 32'(ovf), 0);

    // basic drain with rfd held high
    tick;
    wr_en = 1'b1; wr_data = 8'hA5; t0 = cyc;
    tick;
    wr_en = 1'b0;
    wait_vld(10);
    chk("basic_latency", 32'(cyc - t0), 3);
    chk("basic_din", 32'(uart_din), 32'h A5);
    chk("basic_count", 32'(count), 0);
    chk("basic_empty", 32'(empty), 1);

    // handshake with a slow transmitter
    uart_rfd = 1'b0;
    tick; tick;
    put(8'h11); put(8'h22); put(8'h33);
    out_log.delete();
    xmit(3, 100);
    repeat (5) tick;
    chk("hs_pulses", 32'(out_log.size()), 3);
    chk("hs_word0", log_at(0), 32'h11);
    chk("hs_word1", log_at(1), 32'h22);
    chk("hs_word2", log_at(2), 32'h33);

    // fill and overflow
    uart_rfd = 1'b0;
    tick;
    for (int i = 0; i < 17; i++) begin
      put(8'(8'h40 + i));
      chk("fill_full", 32'(full), 32'(i >= 15));
    end
    chk("fill_count", 32'(count), 16);
    chk("fill_af", 32'(almost_full), 1);
    chk("fill_ovf", 32'(ovf), 32'(OVF_EN));

    // write into a full FIFO on the same edge as the issue pop
    out_log.delete();
    uart_rfd = 1'b1;
    tick;
    wr_en = 1'b1; wr_data = 8'h99;
    tick;
    wr_en = 1'b0;
    chk("rw_vld", 32'(uart_din_vld), 1);
    chk("rw_din", 32'(uart_din), 32'h40);
    chk("rw_count", 32'(count), 16);
    chk("rw_full", 32'(full), 1);
    chk("rw_ovf", 32'(ovf), 32'(OVF_EN));
    tick;
    chk("rw_count_hold", 32'(count), 16);
    uart_rfd = 1'b0;
    tick;
    xmit(16, 3);
    repeat (4) tick;
    chk("rw_pulses", 32'(out_log.size()), 17);
    for (int i = 0; i < 16; i++) chk("rw_order", log_at(i), 32'(8'h40 + i));
    chk("rw_last", log_at(16), 32'h99);

    // wrap-around stream with random transmitter gaps
    out_log.delete();
    fork
      wr_stream;
      tx_random;
    join
    chk("wrap_size", 32'(out_log.size()), 40);
    for (int i = 0; i < 40; i++) chk("wrap_order", log_at(i), 32'(i));

    // reset while waiting for the transmitter with five words still queued
    uart_rfd = 1'b0;
    tick; tick;
    for (int i = 0; i < 6; i++) put(8'(8'h60 + i));
    out_log.delete();
    uart_rfd = 1'b1;
    wait_vld(10);
    chk("mid_din", 32'(uart_din), 32'h60);
    repeat (3) tick;
    chk("mid_count", 32'(count), 5);
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    tick;
    rst = 1'b0; wr_en = 1'b0;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_vld", 32'(uart_din_vld), 0);
    out_log.delete();
    repeat (20) tick;
    chk("mid_no_pulse", 32'(out_log.size()), 0);
    put(8'h77);
    wait_vld(10);
    chk("mid_new_din", 32'(uart_din), 32'h77);
    tick;
    chk("mid_new_pulses", 32'(out_log.size()), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
